cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Writeback arbiter for the out-of-order core: shares the single common data bus (CDB) result port between the functional units (ALU, branch, load/store, multiplier). It picks one completed result per cycle, oldest-in-ROB first, with a starvation guard, and registers the winner onto the CDB. The CDB drives the PRF write, the wakeup of reservation-station tags and ROB completion. It sits between the execute stage and the PRF/ROB writeback stage.

## Interface
- NUM_FU, 4, number of requesting functional units
- DATA_WIDTH, 32, result width
- PHY_WIDTH, 6, physical register tag width
- ROB_WIDTH, 5, ROB index width; ROB depth is 2**ROB_WIDTH
- STARVE_LIMIT, 8, consecutive denied cycles before a requester is forced to win (1..15)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- fu_valid  in  NUM_FU  bit i set: FU i holds a finished result
- fu_ready  out  NUM_FU  bit i set: FU i's result is accepted this cycle (combinational)
- fu_prd  in  NUM_FU*PHY_WIDTH  destination physical tag; FU i uses slice [i*PHY_WIDTH +: PHY_WIDTH]
- fu_data  in  NUM_FU*DATA_WIDTH  result data, same slicing
- fu_rob_idx  in  NUM_FU*ROB_WIDTH  ROB index of the result, same slicing
- fu_has_rd  in  NUM_FU  result writes a register (0 for stores and for branches with no link)
- rob_head  in  ROB_WIDTH  index of the oldest ROB entry
- flush  in  1  pipeline squash (mispredict or exception)
- cdb_valid  out  1  broadcast valid
- cdb_prd  out  PHY_WIDTH  broadcast tag
- cdb_data  out  DATA_WIDTH  broadcast data
- cdb_rob_idx  out  ROB_WIDTH  ROB entry to mark complete
- cdb_we  out  1  PRF write enable: cdb_valid & has_rd of the winner

## Operation
- Handshake: a transfer happens when fu_valid[i] & fu_ready[i]. While fu_valid[i] is high and fu_ready[i] is low, the FU holds prd, data, rob_idx and has_rd stable. fu_ready has no combinational dependence on fu_data.
- At most one fu_ready bit is set per cycle. fu_ready is all zero when flush=1 or when no fu_valid bit is set.
- Age: age_i = (fu_rob_idx_i - rob_head) mod 2**ROB_WIDTH, unsigned, ROB_WIDTH bits, so wrap-around is natural. Smaller age means older.
- Grant priority:
  1. Any valid FU whose starvation counter is >= STARVE_LIMIT wins. If several qualify, the lowest index wins.
  2. Otherwise the valid FU with the minimum age wins. On equal age, the lowest index wins.
- Starvation counters: one 4-bit counter per FU.
  - Increments (saturating at 15) when fu_valid=1 and the FU is not granted.
  - Clears when the FU is granted, when fu_valid=0, or on flush.
- CDB register: on a grant, the winner's fields are latched into cdb_* at the next edge and cdb_valid=1. With no grant, cdb_valid=0 and the other fields hold their last value.
- Flush: no grant in the flush cycle. cdb_valid is 0 on the following cycle, so a result latched in the previous cycle is still broadcast in the flush cycle itself. ROB/PRF drop it using their own flush logic.
- The CDB has no backpressure; the downstream stage accepts one result per cycle unconditionally.

## Timing
- Reset values: cdb_valid=0, cdb_we=0, cdb_prd=0, cdb_data=0, cdb_rob_idx=0, all starvation counters=0. fu_ready=0 while rst is high.
- Latency: a grant in cycle N gives cdb_valid=1 in cycle N+1. Throughput is one result per cycle.
- A single valid requester with no flush is granted in the same cycle it asserts valid.
- Reset asserted mid-transfer clears the CDB register immediately (asynchronous). A granted result is then lost; the core is reset in that case anyway.
- Simultaneous flush and fu_valid: flush wins, no fu_ready, and the counters clear.

## Test plan
- Reset: rst=1 with all fu_valid=1 -> fu_ready=0, cdb_valid=0. Release rst -> the grant follows age order on the first cycle.
- Age order with wrap: rob_head=30, FU0 rob_idx=2, FU1 rob_idx=31 -> FU1 granted (age 1 < 4). Next cycle cdb_rob_idx=31, and FU0 is granted in that cycle.
- Tie/lowest index: FU2 and FU3 carry the same rob_idx=5 -> FU2 granted first, FU3 next cycle. cdb_we follows fu_has_rd (FU3 has_rd=0 -> cdb_valid=1, cdb_we=0).
- Starvation: FU3 is held valid with the youngest age while FU0–FU2 are re-presented with older results every cycle -> FU3 granted no later than the 9th cycle (counter reaches 8).
- Flush: FU1 granted in cycle N, flush=1 in N+1 with FU0 valid -> cdb_valid=1 (FU1 data) in N+1, fu_ready=0 in N+1, cdb_valid=0 in N+2, counters cleared.
- Back-to-back stream: all four FUs valid continuously with distinct ages -> one grant per cycle, cdb_valid stays high, and results appear in ascending age order.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Writeback arbiter for the common data bus. Each cycle it grants one finished FU result,
// oldest in the ROB first, and a starvation guard can override that order.
module cdb_arbiter #(
    parameter int unsigned NUM_FU       = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned PHY_WIDTH    = 6,
    parameter int unsigned ROB_WIDTH    = 5,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_FU-1:0]              fu_valid,
    output logic [NUM_FU-1:0]              fu_ready,
    input  logic [NUM_FU*PHY_WIDTH-1:0]    fu_prd,
    input  logic [NUM_FU*DATA_WIDTH-1:0]   fu_data,
    input  logic [NUM_FU*ROB_WIDTH-1:0]    fu_rob_idx,
    input  logic [NUM_FU-1:0]              fu_has_rd,
    input  logic [ROB_WIDTH-1:0]           rob_head,
    input  logic                           flush,
    output logic                           cdb_valid,
    output logic [PHY_WIDTH-1:0]           cdb_prd,
    output logic [DATA_WIDTH-1:0]          cdb_data,
    output logic [ROB_WIDTH-1:0]           cdb_rob_idx,
    output logic                           cdb_we
);

    localparam int unsigned IdxW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [3:0]            starve_q [NUM_FU];
    logic [3:0]            starve_d [NUM_FU];
    logic [ROB_WIDTH-1:0]  age [NUM_FU];

    logic                  starve_hit;
    logic [IdxW-1:0]       starve_idx;
    logic                  age_hit;
    logic [IdxW-1:0]       age_idx;
    logic [ROB_WIDTH-1:0]  best_age;
    logic                  grant_any;
    logic [IdxW-1:0]       grant_idx;

    logic [PHY_WIDTH-1:0]  win_prd;
    logic [DATA_WIDTH-1:0] win_data;
    logic [ROB_WIDTH-1:0]  win_rob_idx;
    logic                  win_has_rd;

    logic                  cdb_valid_q;
    logic [PHY_WIDTH-1:0]  cdb_prd_q;
    logic [DATA_WIDTH-1:0] cdb_data_q;
    logic [ROB_WIDTH-1:0]  cdb_rob_idx_q;
    logic                  cdb_has_rd_q;

    // Distance from the ROB head; modular subtraction handles wrap-around.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            age[i] = fu_rob_idx[i*ROB_WIDTH +: ROB_WIDTH] - rob_head;
        end
    end

    always_comb begin
        starve_hit = 1'b0;
        starve_idx = '0;
        // Descending scan so the lowest starving index is the one left standing.
        for (int i = int'(NUM_FU) - 1; i >= 0; i--) begin
            if (fu_valid[i] && (starve_q[i] >= 4'(STARVE_LIMIT))) begin
                starve_hit = 1'b1;
                starve_idx = IdxW'(i);
            end
        end

        age_hit  = 1'b0;
        age_idx  = '0;
        best_age = '1;
        for (int i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i] && (!age_hit || (age[i] < best_age))) begin
                age_hit  = 1'b1;
                age_idx  = IdxW'(i);
                best_age = age[i];
            end
        end

        grant_any = !rst && !flush && age_hit;
        grant_idx = starve_hit ? starve_idx : age_idx;
    end

    always_comb begin
        fu_ready = '0;
        if (grant_any) begin
            fu_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        win_prd     = '0;
        win_data    = '0;
        win_rob_idx = '0;
        win_has_rd  = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (IdxW'(i) == grant_idx) begin
                win_prd     = fu_prd[i*PHY_WIDTH +: PHY_WIDTH];
                win_data    = fu_data[i*DATA_WIDTH +: DATA_WIDTH];
                win_rob_idx = fu_rob_idx[i*ROB_WIDTH +: ROB_WIDTH];
                win_has_rd  = fu_has_rd[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (flush || !fu_valid[i] || fu_ready[i]) begin
                starve_d[i] = 4'd0;
            end else if (starve_q[i] != 4'hf) begin
                starve_d[i] = starve_q[i] + 4'd1;
            end else begin
                starve_d[i] = starve_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_FU; i++) begin
                starve_q[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                starve_q[i] <= starve_d[i];
            end
        end
    end

    // Payload fields hold their last value when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid_q   <= 1'b0;
            cdb_prd_q     <= '0;
            cdb_data_q    <= '0;
            cdb_rob_idx_q <= '0;
            cdb_has_rd_q  <= 1'b0;
        end else begin
            cdb_valid_q <= grant_any;
            if (grant_any) begin
                cdb_prd_q     <= win_prd;
                cdb_data_q    <= win_data;
                cdb_rob_idx_q <= win_rob_idx;
                cdb_has_rd_q  <= win_has_rd;
            end
        end
    end

    assign cdb_valid   = cdb_valid_q;
    assign cdb_prd     = cdb_prd_q;
    assign cdb_data    = cdb_data_q;
    assign cdb_rob_idx = cdb_rob_idx_q;
    assign cdb_we      = cdb_valid_q & cdb_has_rd_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a rule-level model of grant and CDB state.
module tb_cdb_arbiter;

    localparam int NF = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [4:0]  rob_head;
    logic [3:0]  v;
    logic [3:0]  hrd;
    logic [5:0]  prd [NF];
    logic [31:0] data [NF];
    logic [4:0]  rob [NF];

    logic [NF-1:0]    fu_ready;
    logic [NF*6-1:0]  fu_prd;
    logic [NF*32-1:0] fu_data;
    logic [NF*5-1:0]  fu_rob_idx;
    logic             cdb_valid;
    logic [5:0]       cdb_prd;
    logic [31:0]      cdb_data;
    logic [4:0]       cdb_rob_idx;
    logic             cdb_we;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    int          m_cnt [NF];
    logic        m_valid;
    logic [5:0]  m_prd;
    logic [31:0] m_data;
    logic [4:0]  m_rob;
    logic        m_hrd;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NF; i++) begin
            fu_prd[i*6 +: 6]      = prd[i];
            fu_data[i*32 +: 32]   = data[i];
            fu_rob_idx[i*5 +: 5]  = rob[i];
        end
    end

    cdb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .fu_valid    (v),
        .fu_ready    (fu_ready),
        .fu_prd      (fu_prd),
        .fu_data     (fu_data),
        .fu_rob_idx  (fu_rob_idx),
        .fu_has_rd   (hrd),
        .rob_head    (rob_head),
        .flush       (flush),
        .cdb_valid   (cdb_valid),
        .cdb_prd     (cdb_prd),
        .cdb_data    (cdb_data),
        .cdb_rob_idx (cdb_rob_idx),
        .cdb_we      (cdb_we)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Grant decision straight from the rules: starving requester first, else smallest age.
    function automatic int model_grant();
        int best;
        int best_age;
        int a;
        best = -1;
        best_age = 1000;
        if (rst || flush) return -1;
        for (int i = 0; i < NF; i++) begin
            if (v[i] && m_cnt[i] >= 8) return i;
        end
        for (int i = 0; i < NF; i++) begin
            if (v[i]) begin
                a = (int'(rob[i]) - int'(rob_head) + 32) % 32;
                if (a < best_age) begin
                    best = i;
                    best_age = a;
                end
            end
        end
        return best;
    endfunction

    always @(posedge clk or posedge rst) begin
        int g;
        if (rst) begin
            for (int i = 0; i < NF; i++) m_cnt[i] <= 0;
            m_valid <= 1'b0;
            m_prd   <= '0;
            m_data  <= '0;
            m_rob   <= '0;
            m_hrd   <= 1'b0;
        end else begin
            g = model_grant();
            for (int i = 0; i < NF; i++) begin
                if (flush || !v[i] || g == i) m_cnt[i] <= 0;
                else m_cnt[i] <= (m_cnt[i] >= 15) ? 15 : m_cnt[i] + 1;
            end
            m_valid <= (g >= 0);
            if (g >= 0) begin
                m_prd  <= prd[g];
                m_data <= data[g];
                m_rob  <= rob[g];
                m_hrd  <= hrd[g];
            end
        end
    end

    always @(negedge clk) begin
        int g;
        logic [3:0] er;
        if (started) begin
            g = model_grant();
            er = (g >= 0) ? 4'(1 << g) : 4'd0;
            chk("model_ready", fu_ready, er);
            chk("model_cdb_valid", cdb_valid, m_valid);
            chk("model_cdb_we", cdb_we, m_valid & m_hrd);
            chk("model_cdb_prd", cdb_prd, m_prd);
            chk("model_cdb_data", cdb_data, m_data);
            chk("model_cdb_rob", cdb_rob_idx, m_rob);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] acc;
        logic [4:0] next_rob;
        int got;

        rst = 1'b0;
        flush = 1'b0;
        rob_head = 5'd0;
        v = 4'b1111;
        hrd = 4'b1111;
        rob[0] = 5'd7;  rob[1] = 5'd4;  rob[2] = 5'd9;  rob[3] = 5'd6;
        for (int i = 0; i < NF; i++) begin
            prd[i] = 6'(10 + i);
            data[i] = 32'h1000 + 32'(i);
        end
        #1 rst = 1'b1;
        started = 1'b1;

        // Reset holds everything quiet even with all requesters valid.
        @(negedge clk);
        chk("rst_ready", fu_ready, 4'b0000);
        chk("rst_cdb_valid", cdb_valid, 1'b0);
        chk("rst_cdb_we", cdb_we, 1'b0);
        chk("rst_cdb_data", cdb_data, 32'd0);
        chk("rst_cdb_prd", cdb_prd, 6'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_age_grant", fu_ready, 4'b0010);
        next_cycle();
        v = 4'b0000;
        @(negedge clk);
        chk("post_rst_cdb_valid", cdb_valid, 1'b1);
        chk("post_rst_cdb_rob", cdb_rob_idx, 5'd4);

        // Age order across the ROB wrap point.
        next_cycle();
        rob_head = 5'd30;
        rob[0] = 5'd2;
        rob[1] = 5'd31;
        v = 4'b0011;
        @(negedge clk);
        chk("wrap_grant_fu1", fu_ready, 4'b0010);
        next_cycle();
        v = 4'b0001;
        @(negedge clk);
        chk("wrap_cdb_rob31", cdb_rob_idx, 5'd31);
        chk("wrap_grant_fu0", fu_ready, 4'b0001);
        next_cycle();
        v = 4'b0000;
        @(negedge clk);
        chk("wrap_cdb_rob2", cdb_rob_idx, 5'd2);

        // Equal age: lower index first, cdb_we follows has_rd.
        next_cycle();
        rob_head = 5'd0;
        rob[2] = 5'd5;  rob[3] = 5'd5;
        prd[2] = 6'd21; prd[3] = 6'd42;
        hrd = 4'b0111;
        v = 4'b1100;
        @(negedge clk);
        chk("tie_grant_fu2", fu_ready, 4'b0100);
        next_cycle();
        v = 4'b1000;
        @(negedge clk);
        chk("tie_grant_fu3", fu_ready, 4'b1000);
        chk("tie_cdb_prd_fu2", cdb_prd, 6'd21);
        chk("tie_cdb_we_fu2", cdb_we, 1'b1);
        next_cycle();
        v = 4'b0000;
        @(negedge clk);
        chk("tie_cdb_valid_fu3", cdb_valid, 1'b1);
        chk("tie_cdb_we_fu3", cdb_we, 1'b0);
        chk("tie_cdb_prd_fu3", cdb_prd, 6'd42);

        // Starvation: FU3 youngest, FU0 keeps presenting older results.
        next_cycle();
        hrd = 4'b1111;
        rob[3] = 5'd20;
        rob[0] = 5'd1;
        v = 4'b1001;
        got = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (fu_ready[3]) begin
                got = n;
                break;
            end
            next_cycle();
            rob[0] = (rob[0] == 5'd1) ? 5'd2 : 5'd1;
        end
        chk("starve_grant_cycle", got, 9);
        next_cycle();
        v = 4'b0000;
        @(negedge clk);
        chk("starve_cdb_rob", cdb_rob_idx, 5'd20);

        // Flush the cycle after a grant.
        next_cycle();
        rob[1] = 5'd10;
        prd[1] = 6'd33;
        data[1] = 32'hdeadbeef;
        v = 4'b0010;
        @(negedge clk);
        chk("flush_pre_grant", fu_ready, 4'b0010);
        next_cycle();
        v = 4'b0001;
        rob[0] = 5'd3;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_ready", fu_ready, 4'b0000);
        chk("flush_cdb_valid", cdb_valid, 1'b1);
        chk("flush_cdb_data", cdb_data, 32'hdeadbeef);
        chk("flush_cdb_rob", cdb_rob_idx, 5'd10);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_after_cdb_valid", cdb_valid, 1'b0);
        chk("flush_after_grant", fu_ready, 4'b0001);
        next_cycle();
        v = 4'b0000;

        // Back-to-back stream in ascending ROB order.
        next_cycle();
        rob_head = 5'd0;
        rob[0] = 5'd3; rob[1] = 5'd1; rob[2] = 5'd0; rob[3] = 5'd2;
        next_rob = 5'd4;
        v = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            acc = fu_ready;
            chk("b2b_onehot", $countones(acc), 1);
            if (k > 0) begin
                chk("b2b_cdb_valid", cdb_valid, 1'b1);
                chk("b2b_cdb_rob", cdb_rob_idx, 5'(k - 1));
            end
            next_cycle();
            for (int i = 0; i < NF; i++) begin
                if (acc[i]) begin
                    rob[i] = next_rob;
                    next_rob = next_rob + 5'd1;
                end
            end
        end
        v = 4'b0000;

        // Randomized traffic, with one asynchronous reset mid-stream.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            acc = fu_ready;
            next_cycle();
            rst = 1'b0;
            for (int i = 0; i < NF; i++) begin
                if (!v[i] || acc[i]) begin
                    if ($urandom_range(0, 99) < 60) begin
                        v[i] = 1'b1;
                        rob[i] = 5'($urandom);
                        prd[i] = 6'($urandom);
                        data[i] = $urandom;
                        hrd[i] = 1'($urandom);
                    end else begin
                        v[i] = 1'b0;
                    end
                end
            end
            flush = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) rob_head = 5'($urandom);
            if (cyc == 1500) begin
                #2 rst = 1'b1;
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
